// File: rtl/lab3_sweep_decoder_if.sv
// Bus bundle for lab3_sweep_decoder.
// Control inputs: enable, mode, A, start, wrap, dwell.
// Status outputs: Dout (one-hot), idx, busy, done.
// master: drives controls, observes status. slave: the decoder itself.
interface lab3_sweep_decoder_if #(
   parameter int unsigned SEL_W   = 5,
   parameter int unsigned DWELL_W = 8
) ();
   localparam int unsigned OUT_W = 2 ** SEL_W;

   logic               enable;
   logic               mode;
   logic [SEL_W-1:0]   A;
   logic               start;
   logic               wrap;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   Dout;
   logic [SEL_W-1:0]   idx;
   logic               busy;
   logic               done;

   modport master (
      output enable, mode, A, start, wrap, dwell,
      input  Dout, idx, busy, done
   );

   modport slave (
      input  enable, mode, A, start, wrap, dwell,
      output Dout, idx, busy, done
   );
endinterface

// File: rtl/lab3_sweep_decoder.sv
// Registered one-hot decoder with a sweep engine.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of lab3_sweep_decoder_if (controls in, Dout/idx/busy/done out)
// mode=0 decodes A directly (1-cycle latency). mode=1 sweeps the index 0..OUT_W-1, holding each
// index for dwell+1 cycles, either one-shot (done pulse) or wrapping.
module lab3_sweep_decoder #(
   parameter int unsigned SEL_W   = 5,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   lab3_sweep_decoder_if.slave      bus
);
   localparam int unsigned OUT_W = 2 ** SEL_W;
   localparam logic [OUT_W-1:0] OneHot0 = {{(OUT_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] IdxLast = {SEL_W{1'b1}};

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   dout_q, dout_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
   logic               done_q, done_d;

   always_comb begin
      state_d     = state_q;
      dout_d      = dout_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      dwell_lat_d = dwell_lat_q;
      done_d      = 1'b0;

      if (!bus.mode) begin
         // Direct decode; also the abort path when mode drops during a sweep.
         state_d = StIdle;
         idx_d   = bus.A;
         dout_d  = bus.enable ? (OneHot0 << bus.A) : '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               dout_d = '0;
               if (bus.enable && bus.start) begin
                  state_d     = StRun;
                  idx_d       = '0;
                  dout_d      = OneHot0;
                  cnt_d       = '0;
                  dwell_lat_d = bus.dwell;
               end
            end
            StRun: begin
               if (!bus.enable) begin
                  dout_d = '0;
               end else if (dout_q == '0) begin
                  // Dout is only zero in RUN after a pause: re-show idx, counter stays frozen.
                  dout_d = OneHot0 << idx_q;
               end else if (cnt_q == dwell_lat_q) begin
                  cnt_d = '0;
                  if (idx_q == IdxLast) begin
                     if (bus.wrap) begin
                        idx_d  = '0;
                        dout_d = OneHot0;
                     end else begin
                        state_d = StIdle;
                        dout_d  = '0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     idx_d  = idx_q + SEL_W'(1);
                     dout_d = OneHot0 << (idx_q + SEL_W'(1));
                  end
               end else begin
                  cnt_d  = cnt_q + DWELL_W'(1);
                  dout_d = OneHot0 << idx_q;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dout_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         dwell_lat_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dout_q      <= dout_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         dwell_lat_q <= dwell_lat_d;
         done_q      <= done_d;
      end
   end

   assign bus.Dout = dout_q;
   assign bus.idx  = idx_q;
   assign bus.busy = (state_q == StRun);
   assign bus.done = done_q;
endmodule

// File: tb/tb_lab3_sweep_decoder.sv
// Directed bench for lab3_sweep_decoder (SEL_W=5, DWELL_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lab3_sweep_decoder;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   lab3_sweep_decoder_if #(.SEL_W(5), .DWELL_W(8)) bus ();

   lab3_sweep_decoder #(.SEL_W(5), .DWELL_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] dout, input int idx,
                          input logic busy, input logic done);
      chk({tag, ".dout"}, bus.Dout, dout);
      chk({tag, ".idx"}, 32'(bus.idx), 32'(idx));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
      chk({tag, ".done"}, 32'(bus.done), 32'(done));
   endtask

   task automatic start_sweep(input logic [7:0] dw);
      bus.mode  = 1'b1;
      bus.dwell = dw;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.mode   = 1'b0;
      bus.A      = '0;
      bus.start  = 1'b0;
      bus.wrap   = 1'b0;
      bus.dwell  = '0;
      #1;
      chk_all("reset", 32'h0, 0, 1'b0, 1'b0);
      repeat (2) step();
      rst_n = 1'b1;

      // Direct mode
      bus.enable = 1'b1;
      bus.A      = 5'd31;
      step();
      chk_all("direct31", 32'h8000_0000, 31, 1'b0, 1'b0);
      bus.enable = 1'b0;
      step();
      chk("direct_blank", bus.Dout, 32'h0);
      bus.enable = 1'b1;
      for (int a = 0; a < 32; a++) begin
         bus.A = 5'(a);
         step();
         chk("direct_sweepA", bus.Dout, 32'h1 << a);
      end

      // One-shot, dwell 0
      bus.wrap = 1'b0;
      start_sweep(8'd0);
      chk_all("os_first", 32'h1, 0, 1'b1, 1'b0);
      bus.start = 1'b1;  // ignored while running
      for (int i = 1; i < 32; i++) begin
         step();
         chk("os_dout", bus.Dout, 32'h1 << i);
         chk("os_done_low", 32'(bus.done), 32'h0);
      end
      bus.start = 1'b0;
      step();
      chk_all("os_end", 32'h0, 31, 1'b0, 1'b1);
      step();
      chk_all("os_after", 32'h0, 31, 1'b0, 1'b0);

      // Dwell 3; the dwell input changing mid-sweep must not matter
      start_sweep(8'd3);
      bus.dwell = 8'd0;
      for (int c = 1; c < 128; c++) begin
         step();
         chk("dw_dout", bus.Dout, 32'h1 << (c / 4));
         chk("dw_done_low", 32'(bus.done), 32'h0);
      end
      step();
      chk_all("dw_end", 32'h0, 31, 1'b0, 1'b1);

      // Wrap and pause
      bus.wrap = 1'b1;
      start_sweep(8'd0);
      for (int i = 1; i < 32; i++) begin
         step();
         chk("wr_done_low", 32'(bus.done), 32'h0);
      end
      chk_all("wr_last", 32'h8000_0000, 31, 1'b1, 1'b0);
      step();
      chk_all("wr_wrap", 32'h1, 0, 1'b1, 1'b0);
      repeat (10) step();
      chk_all("wr_idx10", 32'h400, 10, 1'b1, 1'b0);
      bus.enable = 1'b0;
      for (int p = 0; p < 5; p++) begin
         step();
         chk_all("pause", 32'h0, 10, 1'b1, 1'b0);
      end
      bus.enable = 1'b1;
      step();
      chk_all("resume", 32'h400, 10, 1'b1, 1'b0);
      step();
      chk_all("resume_adv", 32'h800, 11, 1'b1, 1'b0);

      // Abort at idx 7
      bus.mode = 1'b0;
      bus.A    = 5'd2;
      step();
      bus.wrap = 1'b0;
      start_sweep(8'd0);
      repeat (7) step();
      chk_all("ab_idx7", 32'h80, 7, 1'b1, 1'b0);
      bus.mode = 1'b0;
      bus.A    = 5'd5;
      step();
      chk_all("abort", 32'h20, 5, 1'b0, 1'b0);
      step();
      chk("abort_nodone", 32'(bus.done), 32'h0);

      // Async reset mid-sweep at idx 12
      start_sweep(8'd0);
      repeat (12) step();
      chk("rs_idx12", 32'(bus.idx), 32'd12);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("rs_async", 32'h0, 0, 1'b0, 1'b0);
      step();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("rs_idle", 32'h0, 0, 1'b0, 1'b0);
      end
      start_sweep(8'd0);
      chk_all("rs_restart", 32'h1, 0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
